cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of functional-unit requesters (0=arith/comp, 1=mult, 2=branch/div, 3=agen/load).
REQ-002 SHALL have parameter PTR_W, default $clog2(N_REQ), giving the round-robin pointer width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester "result ready to broadcast".
REQ-006 SHALL have port req_data  input  N_REQ x cdb_output_t (186 bits each)  per-requester result payload.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester grant; the result is accepted this cycle.
REQ-008 SHALL have port flush  input  1  branch-mispredict flush; squashes in-flight broadcasts.
REQ-009 SHALL have port cdb_out  output  cdb_output_t  registered common-data-bus broadcast.
REQ-010 SHALL have port rr_ptr  output  PTR_W  current highest-priority requester index, for debug and verification.

Function
REQ-011 SHALL assert at most one req_ready bit per cycle (one-hot or zero).
REQ-012 SHALL assert req_ready[i] only when req_valid[i]=1 and i is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-013 SHALL assert no req_ready bit when flush=1 or rst=1.
REQ-014 SHALL compute req_ready combinationally from req_valid, rr_ptr, flush and rst, with no dependence on req_data.
REQ-015 SHALL treat a requester as completing a handshake when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-016 SHALL require each requester to hold req_valid and req_data stable until granted; a hold is not checked, but a payload change is sampled as-is.
REQ-017 SHALL, on a handshake by requester g, register cdb_out <= req_data[g] with cdb_out.valid forced to 1 at the next edge; latency is 1 cycle.
REQ-018 SHALL register cdb_out.valid <= 0 at the next edge when no handshake occurs; other cdb_out fields are don't-care while valid=0.
REQ-019 SHALL treat the CDB as never back-pressured; every cdb_out with valid=1 is consumed in the cycle it is presented.
REQ-020 SHALL, on a handshake by g, update rr_ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-021 SHALL leave rr_ptr unchanged in any cycle with no handshake.
REQ-022 SHALL, on flush=1, register cdb_out.valid <= 0 at the next edge, even if cdb_out.valid is currently 1; the entry already on the bus this cycle is still broadcast.
REQ-023 SHALL NOT change rr_ptr in a flush cycle.
REQ-024 SHALL guarantee that a continuously-valid requester is granted within N_REQ cycles of its first valid cycle when flush is low (starvation bound).
REQ-025 SHALL sustain throughput of one broadcast per cycle while any requester is valid.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set cdb_out to all-zero (valid=0) and rr_ptr=0.
REQ-027 SHALL hold req_ready all-zero during any rst=1 cycle.
REQ-028 SHALL cause rst asserted mid-operation to discard any pending grant, producing no cdb_out.valid in the cycle after reset.
REQ-029 SHALL resume arbitration in the first cycle with rst=0, with rr_ptr=0.

Verification
REQ-030 SHALL cover single requester: after reset, req_valid=4'b0100 with data=0xDEADBEEF -> req_ready=4'b0100 the same cycle; next cycle cdb_out.valid=1 and data=0xDEADBEEF; rr_ptr=3.
REQ-031 SHALL cover all valid, held four cycles from rr_ptr=0 -> grants in the order 0,1,2,3 and rr_ptr sequence 1,2,3,0, with four consecutive cdb_out.valid=1 cycles.
REQ-032 SHALL cover wrap-around: rr_ptr=3 with req_valid=4'b0011 -> grant 0, then grant 1, then cdb_out.valid=0 once the valid bits are dropped.
REQ-033 SHALL cover flush: req_valid=4'b1111 with flush=1 for one cycle -> req_ready=0, next-cycle cdb_out.valid=0, rr_ptr unchanged, and arbitration resumes the following cycle.
REQ-034 SHALL cover reset mid-stream: rst=1 while req_valid=4'b1000 and rr_ptr=2 -> req_ready=0, cdb_out.valid=0, rr_ptr=0 after the edge; the first grant after release goes to requester 3.
REQ-035 SHALL cover random stress: 10k cycles of random valid/flush with a scoreboard checking REQ-011, REQ-017 and REQ-024, and that each payload is broadcast exactly once unless flushed before its grant.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant across functional units,
// registered single-entry broadcast with flush squash.
package cdb_pkg;

    // One CDB broadcast entry (186 bits).
    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_idx;
        logic [5:0]  prd;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] target_pc;
        logic [31:0] inst;
        logic [4:0]  exc_cause;
        logic        exception;
        logic        mispredict;
        logic        taken;
    } cdb_output_t;

endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic        [N_REQ-1:0]       req_valid,
    input  cdb_output_t [N_REQ-1:0]       req_data,
    output logic        [N_REQ-1:0]       req_ready,
    input  logic                          flush,
    output cdb_output_t                   cdb_out,
    output logic        [PTR_W-1:0]       rr_ptr
);

    cdb_output_t      cdb_q;
    cdb_output_t      cdb_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] gidx;
    logic             hs;

    // Round-robin scan starting at ptr_q; first valid requester wins.
    always_comb begin
        int unsigned idx;
        grant = '0;
        gidx  = '0;
        hs    = 1'b0;
        idx   = 0;
        if (!rst && !flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr_q) + k) % N_REQ;
                if (!hs && req_valid[idx]) begin
                    hs         = 1'b1;
                    grant[idx] = 1'b1;
                    gidx       = PTR_W'(idx);
                end
            end
        end
    end

    // Next bus entry and pointer; pointer only moves on a handshake.
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        ptr_d       = ptr_q;
        if (hs) begin
            cdb_d       = req_data[gidx];
            cdb_d.valid = 1'b1;
            if (gidx == PTR_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q <= '0;
            ptr_q <= '0;
        end else begin
            cdb_q <= cdb_d;
            ptr_q <= ptr_d;
        end
    end

    assign req_ready = grant;
    assign cdb_out   = cdb_q;
    assign rr_ptr    = ptr_q;

endmodule
